// File: rtl/nx_fifo_wm.sv
// nx_fifo_wm: single-clock show-ahead FIFO with any DEPTH.
// It has runtime almost-full and almost-empty thresholds, write-through when full,
// sticky underflow and overflow flags, and an occupancy high-watermark.
module nx_fifo_wm #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 128,
  parameter int DATA_RESET = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic             ren,
  input  logic             clear,
  input  logic             hwm_clear,
  input  logic [WIDTH-1:0] wdata,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] used_slots,
  output logic [CNT_W-1:0] free_slots,
  output logic             underflow,
  output logic             overflow,
  output logic             unf_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] high_watermark
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [CNT_W-1:0] used_reg, used_next;
  logic [CNT_W-1:0] hwm_reg, hwm_next;
  logic             unf_reg, unf_next;
  logic             ovf_reg, ovf_next;
  logic             unf_sticky_reg, unf_sticky_next;
  logic             ovf_sticky_reg, ovf_sticky_next;
  logic             rd_ok, wr_ok, mem_we;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (used_reg == '0);
  assign full  = (used_reg == DEPTH_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write alongside a read.
  assign rd_ok  = ren & ~empty;
  assign wr_ok  = wen & (~full | rd_ok);
  // clear discards a write in the same cycle. Reset is handled in the storage block below.
  assign mem_we = wr_ok & ~clear;

  // Next-state logic for the pointers, occupancy, watermark and error flags.
  always_comb begin
    rptr_next       = rptr_reg;
    wptr_next       = wptr_reg;
    used_next       = used_reg;
    unf_next        = 1'b0;
    ovf_next        = 1'b0;
    unf_sticky_next = unf_sticky_reg;
    ovf_sticky_next = ovf_sticky_reg;
    if (clear) begin
      rptr_next       = '0;
      wptr_next       = '0;
      used_next       = '0;
      unf_sticky_next = 1'b0;
      ovf_sticky_next = 1'b0;
    end else begin
      // The pointers wrap by explicit compare, so DEPTH does not need to be a power of two.
      if (rd_ok) rptr_next = (rptr_reg == LAST_PTR) ? '0 : rptr_reg + PTR_W'(1);
      if (wr_ok) wptr_next = (wptr_reg == LAST_PTR) ? '0 : wptr_reg + PTR_W'(1);
      used_next       = used_reg + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      unf_next        = ren & empty;
      ovf_next        = wen & ~wr_ok;
      unf_sticky_next = unf_sticky_reg | unf_next;
      ovf_sticky_next = ovf_sticky_reg | ovf_next;
    end
    // The watermark uses occupancy after clear, and clear does not reset it.
    if (hwm_clear)                  hwm_next = used_next;
    else if (used_next > hwm_reg)   hwm_next = used_next;
    else                            hwm_next = hwm_reg;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_reg       <= '0;
      wptr_reg       <= '0;
      used_reg       <= '0;
      hwm_reg        <= '0;
      unf_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      unf_sticky_reg <= 1'b0;
      ovf_sticky_reg <= 1'b0;
    end else begin
      rptr_reg       <= rptr_next;
      wptr_reg       <= wptr_next;
      used_reg       <= used_next;
      hwm_reg        <= hwm_next;
      unf_reg        <= unf_next;
      ovf_reg        <= ovf_next;
      unf_sticky_reg <= unf_sticky_next;
      ovf_sticky_reg <= ovf_sticky_next;
    end
  end

  // Each entry is its own register. An entry is zeroed on reset only when DATA_RESET is set.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    // Store write data when the write pointer selects this entry.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        if (DATA_RESET != 0) entry_reg <= '0;
      end else if (mem_we && (wptr_reg == PTR_W'(gi))) begin
        entry_reg <= wdata;
      end
    end

    assign mem[gi] = entry_reg;
  end

  // Show-ahead output: rdata is the head entry, and rdata is zero while the FIFO is empty.
  assign rdata = empty ? '0 : mem[rptr_reg];

  assign used_slots     = used_reg;
  assign free_slots     = DEPTH_CNT - used_reg;
  assign almost_full    = (used_reg >= af_thresh);
  assign almost_empty   = (used_reg <= ae_thresh);
  assign underflow      = unf_reg;
  assign overflow       = ovf_reg;
  assign unf_sticky     = unf_sticky_reg;
  assign ovf_sticky     = ovf_sticky_reg;
  assign high_watermark = hwm_reg;

endmodule

// File: tb/tb_nx_fifo_wm.sv
// Directed testbench for nx_fifo_wm with DEPTH=6 and WIDTH=16.
// The expected values are computed by hand or taken from a small queue model.
module tb_nx_fifo_wm;
  localparam int DEPTH = 6;
  localparam int WIDTH = 16;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n, wen, ren, clear, hwm_clear;
  logic [WIDTH-1:0] wdata;
  logic [CNT_W-1:0] af_thresh, ae_thresh;
  logic [WIDTH-1:0] rdata;
  logic             empty, full, almost_full, almost_empty;
  logic [CNT_W-1:0] used_slots, free_slots, high_watermark;
  logic             underflow, overflow, unf_sticky, ovf_sticky;

  int passes = 0;
  int total  = 0;
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_word;

  always #5 clk = ~clk;

  nx_fifo_wm #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
    .hwm_clear(hwm_clear), .wdata(wdata), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .rdata(rdata), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .used_slots(used_slots), .free_slots(free_slots),
    .underflow(underflow), .overflow(overflow), .unf_sticky(unf_sticky),
    .ovf_sticky(ovf_sticky), .high_watermark(high_watermark)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; clear = 1'b0; hwm_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); wdata = '0;
    af_thresh = 3'd4; ae_thresh = 3'd1;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_used", used_slots, 0);
    chk("rst_free", free_slots, 6);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_hwm", high_watermark, 0);
    chk("rst_sticky", {unf_sticky, ovf_sticky}, 0);

    // Fill to full while checking the thresholds at each step
    for (int i = 0; i < DEPTH; i++) begin
      wen = 1'b1; wdata = 16'h0100 + 16'(i);
      tick();
      $display("write %0h used=%0d", wdata, used_slots);
      chk("fill_used", used_slots, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 4) ? 1 : 0);
      chk("fill_ae", almost_empty, (i + 1 <= 1) ? 1 : 0);
    end
    idle();
    chk("full_flag", full, 1);
    chk("full_free", free_slots, 0);
    chk("full_hwm", high_watermark, 6);
    chk("full_head", rdata, 16'h0100);

    // Full FIFO with a write and a read in the same cycle
    wen = 1'b1; ren = 1'b1; wdata = 16'h00A5;
    tick(); idle();
    chk("wt_used", used_slots, 6);
    chk("wt_ovf", overflow, 0);
    chk("wt_head", rdata, 16'h0101);

    // Full FIFO with a write only
    wen = 1'b1; wdata = 16'h0BAD;
    tick(); idle();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_used", used_slots, 6);
    tick();
    chk("ovf_pulse_end", overflow, 0);
    chk("ovf_sticky_hold", ovf_sticky, 1);

    // Drain in order; 0xA5 comes out last
    for (int i = 0; i < DEPTH; i++) begin
      exp_word = (i == DEPTH - 1) ? 16'h00A5 : 16'h0101 + 16'(i);
      chk("drain_data", rdata, exp_word);
      $display("read %0h", rdata);
      ren = 1'b1;
      tick(); idle();
      chk("drain_used", used_slots, DEPTH - 1 - i);
      chk("drain_af", almost_full, (DEPTH - 1 - i >= 4) ? 1 : 0);
      chk("drain_ae", almost_empty, (DEPTH - 1 - i <= 1) ? 1 : 0);
    end
    chk("drained_empty", empty, 1);
    chk("drained_rdata", rdata, 0);

    // Read from an empty FIFO
    ren = 1'b1;
    tick(); idle();
    chk("unf_pulse", underflow, 1);
    chk("unf_sticky", unf_sticky, 1);
    chk("unf_used", used_slots, 0);
    tick();
    chk("unf_pulse_end", underflow, 0);
    chk("unf_sticky_hold", unf_sticky, 1);

    // Empty FIFO with a write and a read in the same cycle: the write is taken, the read is not
    wen = 1'b1; ren = 1'b1; wdata = 16'h0077;
    chk("nobypass_rdata", rdata, 0);
    tick(); idle();
    chk("er_used", used_slots, 1);
    chk("er_unf", underflow, 1);
    chk("er_rdata", rdata, 16'h0077);
    ren = 1'b1;
    tick(); idle();
    chk("er_pop_used", used_slots, 0);

    // clear drops the sticky flags; hwm_clear reloads the watermark
    clear = 1'b1;
    tick(); idle();
    chk("clr_stickies", {unf_sticky, ovf_sticky}, 0);
    chk("clr_hwm_held", high_watermark, 6);
    hwm_clear = 1'b1;
    tick(); idle();
    chk("hwm_reload", high_watermark, 0);

    // Stream 20 words so the pointers wrap several times
    for (int k = 0; k < 20; k++) begin
      wen = 1'b1; wdata = 16'h0200 + 16'(k);
      ren = (k >= 3);
      if (ren) chk("stream_data", rdata, model_q[0]);
      tick();
      model_q.push_back(wdata);
      if (ren) void'(model_q.pop_front());
      chk("stream_used", used_slots, model_q.size());
    end
    idle();
    chk("stream_hwm", high_watermark, 3);
    while (model_q.size() > 0) begin
      chk("stream_tail", rdata, model_q[0]);
      ren = 1'b1;
      tick(); idle();
      void'(model_q.pop_front());
    end
    chk("stream_empty", empty, 1);

    // Clear in the middle of a stream; the write in the same cycle is ignored
    for (int k = 0; k < 4; k++) begin
      wen = 1'b1; wdata = 16'h0300 + 16'(k);
      tick();
    end
    idle();
    chk("mid_hwm", high_watermark, 4);
    clear = 1'b1; wen = 1'b1; wdata = 16'h0EEE;
    tick(); idle();
    chk("mid_clr_empty", empty, 1);
    chk("mid_clr_used", used_slots, 0);
    chk("mid_clr_hwm", high_watermark, 4);
    chk("mid_clr_rdata", rdata, 0);
    wen = 1'b1; wdata = 16'h0055;
    tick(); idle();
    chk("post_clr_data", rdata, 16'h0055);
    chk("post_clr_used", used_slots, 1);

    // Threshold edge cases with used_slots=1
    af_thresh = 3'd0; #1;
    chk("af_zero", almost_full, 1);
    af_thresh = 3'd7; ae_thresh = 3'd7; #1;
    chk("af_over_depth", almost_full, 0);
    chk("ae_over_depth", almost_empty, 1);
    ae_thresh = 3'd0; #1;
    chk("ae_zero", almost_empty, 0);

    // Reset takes priority over a write in the same cycle
    rst_n = 1'b0; wen = 1'b1; wdata = 16'h0999;
    tick(); idle(); rst_n = 1'b1;
    chk("rst_ovr_used", used_slots, 0);
    chk("rst_ovr_hwm", high_watermark, 0);
    chk("rst_ovr_rdata", rdata, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
